// File: rtl/ccff_chain_loader.sv
// Configuration-chain bitstream writer: serialises host words MSB-first onto ccff_head.
// Define CCFF_CHAIN_LOADER_READBACK_EN to build the ccff_tail readback capture path.
module ccff_chain_loader #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 20
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              cfg_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] shreg_reg, shreg_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [WB_W-1:0]   wbits_reg, wbits_next;
    logic              zero_done_reg, zero_done_next;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            bit_cnt_reg   <= '0;
            wbits_reg     <= '0;
            zero_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bit_cnt_reg   <= bit_cnt_next;
            wbits_reg     <= wbits_next;
            zero_done_reg <= zero_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bit_cnt_next   = bit_cnt_reg;
        wbits_next     = wbits_reg;
        zero_done_next = 1'b0;
        word_ready     = 1'b0;
        cfg_shift_en   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (chain_len != '0) begin
                        bit_cnt_next = chain_len;
                        state_next   = S_FETCH;
                    end else begin
                        zero_done_next = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    shreg_next = word_data;
                    wbits_next = WB_W'(WORD_W);
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cfg_shift_en = 1'b1;
                shreg_next   = shreg_reg << 1;
                bit_cnt_next = bit_cnt_reg - 1'b1;
                wbits_next   = wbits_reg - 1'b1;
                // Chain end takes priority: unused tail bits of the last word are dropped.
                if (bit_cnt_reg == CNT_W'(1)) begin
                    state_next = S_DONE;
                end else if (wbits_reg == WB_W'(1)) begin
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (abort) begin
            state_next     = S_IDLE;
            zero_done_next = 1'b0;
        end
    end

    assign ccff_head = cfg_shift_en & shreg_reg[WORD_W-1];
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE) | zero_done_reg;

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    localparam int RC_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] rbreg_reg;
    logic [WORD_W-1:0] rb_data_reg;
    logic [RC_W-1:0]   rbcnt_reg;
    logic              rb_valid_reg;
    logic [WORD_W-1:0] rb_shift;
    logic [WORD_W-1:0] rb_mask;

    assign rb_shift = {rbreg_reg[WORD_W-2:0], ccff_tail};
    // Keeps only the rbcnt freshest bits so a partial word leaves zeros above.
    assign rb_mask  = ~({WORD_W{1'b1}} << rbcnt_reg);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rbreg_reg    <= '0;
            rb_data_reg  <= '0;
            rbcnt_reg    <= '0;
            rb_valid_reg <= 1'b0;
        end else begin
            rb_valid_reg <= 1'b0;
            if (abort || (state_reg == S_IDLE && start)) begin
                rbreg_reg <= '0;
                rbcnt_reg <= '0;
            end else if (cfg_shift_en) begin
                rbreg_reg <= rb_shift;
                if (rbcnt_reg == RC_W'(WORD_W - 1)) begin
                    rb_data_reg  <= rb_shift;
                    rb_valid_reg <= 1'b1;
                    rbcnt_reg    <= '0;
                end else begin
                    rbcnt_reg <= rbcnt_reg + 1'b1;
                end
            end else if (state_reg == S_DONE && rbcnt_reg != '0) begin
                rb_data_reg  <= rbreg_reg & rb_mask;
                rb_valid_reg <= 1'b1;
                rbcnt_reg    <= '0;
                rbreg_reg    <= '0;
            end
        end
    end

    assign rb_data  = rb_data_reg;
    assign rb_valid = rb_valid_reg;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a behavioural chain model drives ccff_tail and
// expected serial bits, done pulses and readback words are queued and checked by a monitor.
module tb_ccff_chain_loader;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 20;

    logic              prog_clk = 1'b0;
    logic              prog_reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  chain_len = '0;
    logic [WORD_W-1:0] word_data = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              ccff_head;
    logic              cfg_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    ccff_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .abort        (abort),
        .chain_len    (chain_len),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (ccff_head),
        .cfg_shift_en (cfg_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural configuration chain: ch[0] is the newest bit, tail sits at ch_len-1.
    logic [255:0] ch = '0;
    int           ch_len = 1;
    always_comb ccff_tail = ch[ch_len-1];
    always @(posedge prog_clk) if (cfg_shift_en) ch <= {ch[254:0], ccff_head};

    int vectors = 0;
    int miscompares = 0;
    bit                exp_bits[$];
    int                exp_done[$];
    logic [WORD_W-1:0] exp_rb[$];
    int                n_shift = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a bit, a done or a readback word.
    always @(negedge prog_clk) begin
        if (prog_reset_n) begin
            if (cfg_shift_en) begin
                n_shift++;
                if (exp_bits.size() == 0) check("extra_shift", 1, 0);
                else check("head_bit", ccff_head, exp_bits.pop_front());
            end else begin
                check("head_gated", ccff_head, 0);
            end
            if (done) begin
                if (exp_done.size() == 0) check("extra_done", 1, 0);
                else check("done_shifts", n_shift, exp_done.pop_front());
            end
            if (rb_valid) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                if (exp_rb.size() == 0) check("extra_rb", 1, 0);
                else check("rb_data", rb_data, exp_rb.pop_front());
`else
                check("rb_valid_off", rb_valid, 0);
`endif
            end
            if (word_ready) check("ready_busy", busy, 1);
        end
    end

    task automatic flush_scoreboard();
        exp_bits.delete();
        exp_done.delete();
        exp_rb.delete();
    endtask

    // Expected stream: the first len bits of the words, MSB first; readback is the old chain.
    task automatic queue_load(input int len, ref logic [WORD_W-1:0] words[$]);
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] acc;
        int                cnt;
        for (int i = 0; i < len; i++) begin
            w = words[i / WORD_W];
            exp_bits.push_back(w[WORD_W-1-(i % WORD_W)]);
        end
        exp_done.push_back(len);
        ch_len = len;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        acc = '0;
        cnt = 0;
        for (int i = 0; i < len; i++) begin
            acc = (acc << 1) | WORD_W'(ch[len-1-i]);
            cnt++;
            if (cnt == WORD_W) begin
                exp_rb.push_back(acc);
                acc = '0;
                cnt = 0;
            end
        end
        if (cnt != 0) exp_rb.push_back(acc);
`else
        acc = '0;
        cnt = 0;
`endif
    endtask

    // mode 0: valid held high; 1: random valid + start while busy; 2: 5-cycle stall per word;
    // 3: abort on the 10th shift cycle.
    task automatic run_load(input int len, input int mode, input logic [WORD_W-1:0] fixed);
        logic [WORD_W-1:0] words[$];
        int nw, idx, sc, busy_cyc, stall, fetch_wait;
        bit hs, got_done, injected, aborted, stop;
        nw = (len + WORD_W - 1) / WORD_W;
        for (int i = 0; i <= nw; i++) words.push_back($urandom());
        if (fixed != '0) words[0] = fixed;
        queue_load(len, words);
        n_shift = 0;
        idx = 0; sc = 0; busy_cyc = 0; stall = 0; fetch_wait = 0;
        got_done = 0; injected = 0; aborted = 0; stop = 0;
        chain_len = CNT_W'(len);
        start = 1'b1;
        word_data = words[0];
        for (int cyc = 0; cyc < len * 8 + 100 && !stop; cyc++) begin
            @(negedge prog_clk);
            hs = word_valid && word_ready;
            if (busy) busy_cyc++;
            if (cfg_shift_en) sc++;
            if (mode == 2 && word_ready && !word_valid) begin
                check("stall_no_shift", cfg_shift_en, 0);
                stall++;
                fetch_wait++;
            end
            if (hs) fetch_wait = 0;
            if (done) got_done = 1;
            @(posedge prog_clk);
            #1;
            start = 1'b0;
            if (aborted) stop = 1;
            abort = 1'b0;
            if (hs) idx++;
            if (got_done) stop = 1;
            case (mode)
                1: word_valid = ($urandom_range(0, 3) != 0);
                2: word_valid = (fetch_wait >= 5);
                default: word_valid = 1'b1;
            endcase
            word_data = words[idx];
            if (mode == 1 && sc == 3 && !injected) begin
                start = 1'b1;
                chain_len = CNT_W'(5);
                injected = 1;
            end
            if (mode == 3 && sc == 9 && !aborted) begin
                abort = 1'b1;
                start = 1'b1;
                chain_len = CNT_W'(7);
                aborted = 1;
            end
        end
        word_valid = 1'b0;
        if (mode == 3) begin
            flush_scoreboard();
            check("abort_shifts", sc, 10);
            for (int i = 0; i < 4; i++) begin
                @(negedge prog_clk);
                check("abort_idle_busy", busy, 0);
                check("abort_no_done", done, 0);
                check("abort_no_shift", cfg_shift_en, 0);
            end
            @(posedge prog_clk);
            #1;
        end else begin
            check("done_seen", got_done, 1);
            check("handshakes", idx, nw);
            check("shift_cycles", sc, len);
            if (mode == 0) check("busy_cycles", busy_cyc, len + nw + 1);
            if (mode == 2) check("stall_cycles", stall, 5 * nw);
            if (!got_done) flush_scoreboard();
            repeat (3) @(posedge prog_clk);
            #1;
            check("bits_drained", exp_bits.size(), 0);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            check("rb_drained", exp_rb.size(), 0);
`endif
        end
        $display("load len=%0d mode=%0d words=%0d handshakes=%0d shifts=%0d done=%0d",
                 len, mode, nw, idx, sc, got_done);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_shift_en"}, cfg_shift_en, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_ready"}, word_ready, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rb_valid"}, rb_valid, 0);
        check({tag, "_rb_data"}, rb_data, 0);
    endtask

    task automatic zero_length();
        n_shift = 0;
        exp_done.push_back(0);
        chain_len = '0;
        start = 1'b1;
        @(negedge prog_clk);
        check("zl_done_early", done, 0);
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        @(negedge prog_clk);
        check("zl_done", done, 1);
        check("zl_busy", busy, 0);
        @(negedge prog_clk);
        check("zl_done_once", done, 0);
        @(posedge prog_clk);
        #1;
        $display("load len=0 done pulse only");
    endtask

    task automatic reset_mid_shift();
        logic [WORD_W-1:0] words[$];
        int sc;
        for (int i = 0; i < 3; i++) words.push_back($urandom());
        queue_load(64, words);
        n_shift = 0;
        sc = 0;
        chain_len = CNT_W'(64);
        start = 1'b1;
        word_valid = 1'b1;
        word_data = words[0];
        for (int c = 0; c < 200 && sc < 20; c++) begin
            @(negedge prog_clk);
            if (cfg_shift_en) sc++;
            @(posedge prog_clk);
            #1;
            start = 1'b0;
        end
        check("rst_reached_shift", sc, 20);
        #2;
        prog_reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        flush_scoreboard();
        word_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        check("rst_release_busy", busy, 0);
        check("rst_release_ready", word_ready, 0);
        @(posedge prog_clk);
        #1;
        $display("reset asserted after %0d shifts, returned to idle", sc);
    endtask

    initial begin
        #2;
        check_all_zero("por");
        repeat (2) @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        @(posedge prog_clk);
        #1;
        run_load(8, 0, 32'hA500_0000);
        zero_length();
        run_load(70, 0, '0);
        run_load(40, 2, '0);
        for (int i = 0; i < 4; i++) run_load($urandom_range(1, 150), 1, '0);
        run_load(100, 3, '0);
        reset_mid_shift();
        run_load(32, 0, 32'hDEAD_BEEF);
        run_load(32, 0, '0);
        run_load(36, 0, '0);
        run_load($urandom_range(1, 150), 1, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
